// File: rtl/tick_gen_pkg.sv
// ----------------------------------------------------------------------------
// tick_gen_pkg
// Shared constants and helpers for tick_generator.
//   CLK_FREQ_DEFAULT : default system clock frequency in Hz
//   half10_cycles()  : clock cycles per half period of the 10 Hz output
//   cnt_width()      : width of a counter that must hold 0..n-1
//   DEC_*            : decade counter constants (10 Hz -> 1 Hz)
// Build option: define TICK_GENERATOR_SIM_FAST_EN to force the 10 Hz half
// period to 5 cycles, whatever CLK_FREQ is (short simulations).
// ----------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int CLK_FREQ_DEFAULT = 100_000_000;

`ifdef TICK_GENERATOR_SIM_FAST_EN
    localparam bit SIM_FAST = 1'b1;
`else
    localparam bit SIM_FAST = 1'b0;
`endif

    localparam int SIM_FAST_HALF10 = 5;

    // Decade counter: ten 10 Hz periods make one 1 Hz period, and clk_1hz
    // toggles at the middle and at the end of the decade.
    localparam int                DEC_MODULUS = 10;
    localparam int                DEC_W       = $clog2(DEC_MODULUS);
    localparam logic [DEC_W-1:0]  DEC_MID     = DEC_W'(4);
    localparam logic [DEC_W-1:0]  DEC_LAST    = DEC_W'(DEC_MODULUS - 1);

    function automatic int half10_cycles(input int clk_freq);
        return SIM_FAST ? SIM_FAST_HALF10 : clk_freq / 20;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, both flops clear to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // NOTE: clocked state is written with <= so both flops sample their
    // inputs from before the edge; with = r_sync would see the new r_meta
    // and the two stages would collapse into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/tick_generator.sv
// ----------------------------------------------------------------------------
// tick_generator
// Derives 10 Hz and 1 Hz square waves and single-cycle ticks from the system
// clock, plus a tick selected by a synchronized speed request that only
// changes on 1 Hz boundaries.
//   CLK_FREQ      : system clock in Hz (multiple of 20, at least 40)
//   clk           : system clock, all state updates on the rising edge
//   rst           : synchronous active-high reset
//   speed         : asynchronous request, 0 = 10 Hz ticks, 1 = 1 Hz ticks
//   clk_10hz      : registered 10 Hz square wave, 50% duty
//   clk_1hz       : registered 1 Hz square wave, rises with clk_10hz
//   tick_10hz     : one-cycle pulse in the first high cycle of clk_10hz
//   tick_1hz      : one-cycle pulse in the first high cycle of clk_1hz
//   speed_applied : speed setting currently in effect
//   tick_sel      : tick_10hz or tick_1hz depending on speed_applied
// Build option: TICK_GENERATOR_SIM_FAST_EN shortens the 10 Hz half period to
// 5 cycles (see tick_gen_pkg).
// ----------------------------------------------------------------------------
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic speed,
    output logic clk_10hz,
    output logic clk_1hz,
    output logic tick_10hz,
    output logic tick_1hz,
    output logic speed_applied,
    output logic tick_sel
);

    localparam int               HALF10   = half10_cycles(CLK_FREQ);
    localparam int               CNT_W    = cnt_width(HALF10);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF10 - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [DEC_W-1:0] r_dec;
    logic             r_dec_run;
    logic             r_clk_10hz;
    logic             r_clk_1hz;
    logic             r_tick_10hz;
    logic             r_tick_1hz;
    logic             r_speed_applied;

    logic w_speed_sync;
    logic w_half_end;
    logic w_rise_10hz;
    logic w_toggle_1hz;
    logic w_rise_1hz;

    sync_2ff u_speed_sync (
        .clk (clk),
        .rst (rst),
        .d   (speed),
        .q   (w_speed_sync)
    );

    assign w_half_end  = (r_cnt == CNT_LAST);
    assign w_rise_10hz = w_half_end & ~r_clk_10hz;

    // The decade counter counts complete 10 Hz periods, so it only starts
    // advancing from the second 10 Hz rise after reset. That places the first
    // clk_1hz rise at the sixth 10 Hz rise (11 half periods after reset) and
    // every later toggle five 10 Hz periods apart.
    assign w_toggle_1hz = w_rise_10hz & r_dec_run &
                          ((r_dec == DEC_MID) | (r_dec == DEC_LAST));
    assign w_rise_1hz   = w_toggle_1hz & ~r_clk_1hz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_dec           <= '0;
            r_dec_run       <= 1'b0;
            r_clk_10hz      <= 1'b0;
            r_clk_1hz       <= 1'b0;
            r_tick_10hz     <= 1'b0;
            r_tick_1hz      <= 1'b0;
            r_speed_applied <= 1'b0;
        end else begin
            r_cnt <= w_half_end ? '0 : r_cnt + 1'b1;

            if (w_half_end) begin
                r_clk_10hz <= ~r_clk_10hz;
            end
            r_tick_10hz <= w_rise_10hz;

            if (w_rise_10hz) begin
                r_dec_run <= 1'b1;
                if (r_dec_run) begin
                    r_dec <= (r_dec == DEC_LAST) ? '0 : r_dec + 1'b1;
                end
            end

            if (w_toggle_1hz) begin
                r_clk_1hz <= ~r_clk_1hz;
            end
            r_tick_1hz <= w_rise_1hz;

            // Loaded by the registered tick, so the new setting takes effect
            // in the cycle after the 1 Hz tick; the tick cycle itself still
            // selects with the old setting. Both ticks are high then, so the
            // boundary pulse appears exactly once either way.
            if (r_tick_1hz) begin
                r_speed_applied <= w_speed_sync;
            end
        end
    end

    assign clk_10hz      = r_clk_10hz;
    assign clk_1hz       = r_clk_1hz;
    assign tick_10hz     = r_tick_10hz;
    assign tick_1hz      = r_tick_1hz;
    assign speed_applied = r_speed_applied;
    assign tick_sel      = r_speed_applied ? r_tick_1hz : r_tick_10hz;

endmodule
